// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the single SDRAM controller port among NUM_PORTS requesters.
// One transaction in flight at a time; adds two cycles (RELEASE + IDLE) over controller latency.
module sdram_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDRESS_WIDTH = 21,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    port_data_in,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  port_nwr,
    input  logic [NUM_PORTS-1:0]               port_req,
    output logic [NUM_PORTS-1:0]               port_ack,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    port_data_out,
    output logic [NUM_PORTS-1:0]               grant,
    output logic [ADDRESS_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]              mem_data_out,
    output logic [DATA_WIDTH/8-1:0]            mem_nwr,
    output logic                               mem_req,
    input  logic                               mem_ack,
    input  logic [DATA_WIDTH-1:0]              mem_data_in
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    state_t                          state, state_nxt;
    logic [PW-1:0]                   ptr, ptr_nxt;
    logic [NUM_PORTS-1:0]            grant_nxt;
    logic [NUM_PORTS-1:0]            ack_nxt;
    logic [NUM_PORTS-1:0]            eligible;
    logic                            mem_req_nxt;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dout_nxt;
    logic [PW-1:0]                   pick;
    logic                            pick_vld;

    // A port already holding its ack must drop req once before it can win again.
    assign eligible = port_req & ~port_ack;

    always_comb begin : arb_scan
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!pick_vld && eligible[idx]) begin
                pick_vld = 1'b1;
                pick     = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        grant_nxt   = grant;
        mem_req_nxt = mem_req;
        ack_nxt     = port_ack & port_req;
        dout_nxt    = port_data_out;
        case (state)
            IDLE: begin
                // A still-high mem_ack belongs to the previous transaction; wait it out.
                if (!mem_ack && pick_vld) begin
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    ptr_nxt         = pick;
                    mem_req_nxt     = 1'b1;
                    state_nxt       = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    dout_nxt[int'(ptr)*DATA_WIDTH +: DATA_WIDTH] = mem_data_in;
                    ack_nxt[ptr] = port_req[ptr];
                    mem_req_nxt  = 1'b0;
                    state_nxt    = RELEASE;
                end
            end
            RELEASE: begin
                if (!mem_ack) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                grant_nxt   = '0;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_address  = '0;
        mem_data_out = '0;
        mem_nwr      = '1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                mem_address  = port_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                mem_data_out = port_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                mem_nwr      = port_nwr[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= PW'(NUM_PORTS - 1);
            grant         <= '0;
            mem_req       <= 1'b0;
            port_ack      <= '0;
            port_data_out <= '0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            grant         <= grant_nxt;
            mem_req       <= mem_req_nxt;
            port_ack      <= ack_nxt;
            port_data_out <= dout_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: transaction-level round-robin model plus a reactive controller model.
module tb_sdram_arbiter;

    localparam int NP = 2;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP*AW-1:0] port_address;
    logic [NP*DW-1:0] port_data_in;
    logic [NP*BW-1:0] port_nwr;
    logic [NP-1:0]    port_req;
    logic [NP-1:0]    port_ack;
    logic [NP*DW-1:0] port_data_out;
    logic [NP-1:0]    grant;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_data_out;
    logic [BW-1:0]    mem_nwr;
    logic             mem_req;
    logic             mem_ack;
    logic [DW-1:0]    mem_data_in;

    logic [AW-1:0] a_in [NP];
    logic [DW-1:0] d_in [NP];
    logic [BW-1:0] w_in [NP];

    // reference model state
    int            m_g;
    bit            m_done;
    logic [NP-1:0] m_ack;
    int            m_last;
    logic [DW-1:0] m_dout [NP];
    int            gq [$];

    // environment knobs and controller model state
    logic [NP-1:0] auto_en;
    bit            eager, viol_en, fix_data_en;
    int            fix_lat, fix_sticky;
    logic [DW-1:0] fix_data;
    int            c_ph, c_cnt, c_sticky;

    int n_checks = 0;
    int n_err    = 0;

    sdram_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .port_address(port_address), .port_data_in(port_data_in), .port_nwr(port_nwr),
        .port_req(port_req), .port_ack(port_ack), .port_data_out(port_data_out),
        .grant(grant), .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_nwr(mem_nwr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data_in(mem_data_in)
    );

    initial forever #5 clk = ~clk;

    always_comb begin
        port_address = '0;
        port_data_in = '0;
        port_nwr     = '0;
        for (int i = 0; i < NP; i++) begin
            port_address[i*AW +: AW] = a_in[i];
            port_data_in[i*DW +: DW] = d_in[i];
            port_nwr[i*BW +: BW]     = w_in[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NP-1:0] el);
        for (int k = 1; k <= NP; k++)
            if (el[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    // Advance one cycle: account for the edge just taken, compare, then react as requesters/controller.
    task automatic step();
        logic [NP-1:0] elig, oh, nack;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [BW-1:0] en;
        bit            comp;
        @(negedge clk);
        elig = port_req & ~m_ack;
        comp = 1'b0;
        if (m_g < 0) begin
            if (!mem_ack && elig != '0) begin
                m_g    = rr_pick(m_last, elig);
                m_last = m_g;
                m_done = 1'b0;
                for (int i = 0; i < NP; i++) if (grant[i]) gq.push_back(i);
            end
        end else if (!m_done) begin
            if (mem_ack) begin
                comp         = 1'b1;
                m_done       = 1'b1;
                m_dout[m_g]  = mem_data_in;
            end
        end else if (!mem_ack) begin
            m_g = -1;
        end
        for (int p = 0; p < NP; p++)
            nack[p] = (comp && p == m_g) ? port_req[p] : (m_ack[p] & port_req[p]);
        m_ack = nack;
        oh = '0; ea = '0; ed = '0; en = '1;
        if (m_g >= 0) begin
            oh[m_g] = 1'b1; ea = a_in[m_g]; ed = d_in[m_g]; en = w_in[m_g];
        end
        check("grant", 64'(grant), 64'(oh));
        check("mem_req", 64'(mem_req), 64'(m_g >= 0 && !m_done));
        check("port_ack", 64'(port_ack), 64'(m_ack));
        for (int p = 0; p < NP; p++)
            check($sformatf("dout%0d", p), 64'(port_data_out[p*DW +: DW]), 64'(m_dout[p]));
        check("mem_address", 64'(mem_address), 64'(ea));
        check("mem_data_out", 64'(mem_data_out), 64'(ed));
        check("mem_nwr", 64'(mem_nwr), 64'(en));

        for (int p = 0; p < NP; p++) begin
            if (auto_en[p]) begin
                if (!port_req[p]) begin
                    if (eager || $urandom_range(0, 2) == 0) begin
                        a_in[p]     = AW'($urandom);
                        d_in[p]     = $urandom;
                        w_in[p]     = ($urandom_range(0, 1) == 0) ? '1 : BW'($urandom);
                        port_req[p] = 1'b1;
                    end
                end else if (port_ack[p]) begin
                    if (eager || $urandom_range(0, 3) != 0) port_req[p] = 1'b0;
                end else if (viol_en && $urandom_range(0, 59) == 0) begin
                    port_req[p] = 1'b0;
                end
            end
        end
        if (c_ph == 0 && mem_req) begin
            c_ph  = 1;
            c_cnt = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 5));
        end
        if (c_ph == 1) begin
            c_cnt--;
            if (c_cnt <= 0) begin
                mem_data_in = fix_data_en ? fix_data : $urandom;
                mem_ack     = 1'b1;
                c_sticky    = (fix_sticky >= 0) ? fix_sticky : int'($urandom_range(0, 3));
                c_ph        = 2;
            end
        end else if (c_ph == 2 && !mem_req) begin
            if (c_sticky == 0) begin
                mem_ack = 1'b0;
                c_ph    = 0;
            end else begin
                c_sticky--;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        port_req = '0;
        mem_ack  = 1'b0;
        c_ph     = 0;
        m_g      = -1;
        m_done   = 1'b0;
        m_ack    = '0;
        m_last   = NP - 1;
        for (int p = 0; p < NP; p++) m_dout[p] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int p, input string tag);
        int n = 0;
        while (!grant[p] && n < 60) begin step(); n++; end
        check(tag, 64'(grant[p]), 64'd1);
    endtask

    task automatic wait_ack(input int p, input string tag);
        int n = 0;
        while (!port_ack[p] && n < 60) begin step(); n++; end
        check(tag, 64'(port_ack[p]), 64'd1);
    endtask

    initial begin
        int n;
        for (int p = 0; p < NP; p++) begin
            a_in[p] = '0; d_in[p] = '0; w_in[p] = '1;
        end
        auto_en = '0; eager = 1'b0; viol_en = 1'b0;
        fix_lat = 4; fix_sticky = 0; fix_data_en = 1'b1; fix_data = 32'hDEADBEEF;
        mem_data_in = '0;
        do_reset();
        repeat (2) step();

        // single read on port 1
        a_in[1] = 21'h012345; w_in[1] = '1; port_req[1] = 1'b1;
        wait_grant(1, "rd_grant");
        check("rd_addr", 64'(mem_address), 64'h012345);
        check("rd_nwr", 64'(mem_nwr), 64'hF);
        wait_ack(1, "rd_ack");
        check("rd_data", 64'(port_data_out[DW +: DW]), 64'hDEADBEEF);
        check("rd_p0_untouched", 64'(port_data_out[0 +: DW]), 64'h0);
        port_req[1] = 1'b0;
        repeat (3) step();

        // single write on port 0
        a_in[0] = 21'h1ABCDE; d_in[0] = 32'hA5A5A5A5; w_in[0] = 4'b0000; port_req[0] = 1'b1;
        wait_grant(0, "wr_grant");
        check("wr_nwr", 64'(mem_nwr), 64'h0);
        check("wr_data", 64'(mem_data_out), 64'hA5A5A5A5);
        wait_ack(0, "wr_ack");
        port_req[0] = 1'b0;
        repeat (3) step();

        // contention straight after reset
        do_reset();
        fix_lat = 2; fix_data_en = 1'b0; eager = 1'b1; auto_en = '1;
        gq.delete();
        n = 0;
        while (gq.size() < 4 && n < 100) begin step(); n++; end
        check("cont_count", 64'(gq.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++)
            check($sformatf("cont_order%0d", i), 64'((i < gq.size()) ? gq[i] : -1), 64'(i % 2));
        auto_en = '0; eager = 1'b0; port_req = '0;
        repeat (20) step();

        // sticky controller ack delays the next grant
        fix_sticky = 3;
        a_in[0] = 21'h000777; d_in[0] = 32'h11112222; w_in[0] = '1; port_req[0] = 1'b1;
        wait_grant(0, "sticky_g0");
        a_in[1] = 21'h000888; d_in[1] = 32'h33334444; w_in[1] = '1; port_req[1] = 1'b1;
        wait_ack(0, "sticky_ack0");
        n = 0;
        while (!grant[1] && n < 20) begin step(); n++; end
        check("sticky_gap", 64'(n), 64'd5);
        wait_ack(1, "sticky_ack1");
        port_req = '0;
        repeat (10) step();
        fix_sticky = 0;

        // requester abandons its request mid-transaction
        fix_lat = 3; fix_data_en = 1'b1; fix_data = 32'h13579BDF;
        port_req[1] = 1'b1;
        wait_grant(1, "viol_grant");
        port_req[1] = 1'b0;
        n = 0;
        while (grant != '0 && n < 30) begin step(); n++; end
        check("viol_ack", 64'(port_ack[1]), 64'd0);
        check("viol_data", 64'(port_data_out[DW +: DW]), 64'h13579BDF);
        port_req[0] = 1'b1;
        wait_grant(0, "viol_next");
        wait_ack(0, "viol_next_ack");
        port_req[0] = 1'b0;
        repeat (5) step();

        // asynchronous reset while port 1 is in flight and port 0 holds its ack
        fix_data_en = 1'b0;
        port_req[0] = 1'b1;
        wait_ack(0, "arst_ack0");
        port_req[1] = 1'b1;
        n = 0;
        while (!(grant[1] && mem_req) && n < 30) begin step(); n++; end
        check("arst_busy", 64'(grant[1] && mem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_req", 64'(mem_req), 64'd0);
        check("arst_grant", 64'(grant), 64'd0);
        check("arst_ack", 64'(port_ack), 64'd0);
        check("arst_dout", 64'(port_data_out), 64'd0);
        do_reset();
        repeat (2) step();

        // randomized traffic
        fix_lat = 0; fix_sticky = -1; viol_en = 1'b1; auto_en = '1;
        repeat (3000) step();
        auto_en = '0; port_req = '0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that shares the single CPU-side port of the SDRAM controller among NUM_PORTS requesters (e.g. CPU, video fetch, DMA). It sits between the requesters and the controller, forwards one transaction at a time, and returns read data and acknowledge to the granted requester. Each requester sees the same req/ack handshake the controller itself uses.

## Interface
- NUM_PORTS, 2, number of requesters (2..4)
- ADDRESS_WIDTH, 21, word address width (bank+row+column)
- DATA_WIDTH, 32, data width; DATA_WIDTH/8 byte lanes

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- port_address  in  NUM_PORTS*ADDRESS_WIDTH  flattened; port i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- port_data_in  in  NUM_PORTS*DATA_WIDTH  write data, flattened likewise
- port_nwr  in  NUM_PORTS*DATA_WIDTH/8  active-low byte write enables; all ones = read
- port_req  in  NUM_PORTS  request, held high until matching port_ack
- port_ack  out  NUM_PORTS  acknowledge, held until port_req drops
- port_data_out  out  NUM_PORTS*DATA_WIDTH  per-port registered read data
- grant  out  NUM_PORTS  one-hot granted port, zero when idle
- mem_address  out  ADDRESS_WIDTH  to controller cpu_address
- mem_data_out  out  DATA_WIDTH  to controller cpu_data_in
- mem_nwr  out  DATA_WIDTH/8  to controller cpu_nwr
- mem_req  out  1  to controller cpu_req
- mem_ack  in  1  from controller cpu_ack
- mem_data_in  in  DATA_WIDTH  from controller cpu_data_out

## Operation
- Reset: state IDLE, mem_req=0, grant=0, port_ack=0, port_data_out=0, rr pointer = NUM_PORTS-1 (port 0 wins first).
- Eligible port i: port_req[i]=1 and port_ack[i]=0.
- States: IDLE, BUSY, RELEASE.
- IDLE: if mem_ack=0 and any port eligible, choose first eligible port scanning from pointer+1 upward with wrap; grant<=onehot(i), pointer<=i, mem_req<=1, go BUSY. If mem_ack=1, stay IDLE (controller still acknowledging previous transaction).
- mem_address, mem_data_out, mem_nwr: combinational mux of the granted port's inputs; when grant=0 drive address/data 0 and mem_nwr all ones.
- BUSY: hold mem_req=1. On mem_ack=1: port_data_out[g]<=mem_data_in (reads and writes both capture; writes capture don't-care), port_ack[g]<=port_req[g], mem_req<=0, go RELEASE.
- RELEASE: grant held (mux stable); when mem_ack=0, grant<=0, go IDLE.
- port_ack[i] clears on the first edge where port_req[i]=0, in any state.
- Requester drops port_req mid-transaction (protocol violation): transaction still completes at controller, port_ack not set, data_out still updated.
- port_data_out[i] holds value until port i's next completion.
- Round robin: a port completing is lowest priority next arbitration; no port waits more than NUM_PORTS-1 transactions.

## Timing
- Arbitration: port_req sampled at edge k (IDLE, mem_ack=0) -> grant and mem_req high after edge k.
- Completion: mem_ack first sampled high at edge m -> port_ack high after edge m; mem_req low after edge m.
- Turnaround: next grant no earlier than the edge after mem_ack sampled low; minimum 1 cycle in RELEASE, 1 in IDLE.
- Back-to-back same port: port must drop req for at least one edge (ack clear) before it is eligible again.
- Total arbiter overhead per transaction: 2 cycles over controller latency.
- Reset asserted mid-BUSY: outputs return to reset values immediately (asynchronous); controller transaction in flight is abandoned.

## Test plan
- Reset: assert reset mid-BUSY -> mem_req=0, grant=0, port_ack=0 asynchronously, port_data_out=0.
- Single read: port1 reads address 0x012345, model returns 0xDEADBEEF 4 cycles after mem_req -> port_ack[1] one cycle after mem_ack, port_data_out[1]=0xDEADBEEF, port 0 outputs untouched.
- Single write: port0 nwr=4'b0000, data 0xA5A5A5A5 -> mem_nwr=0, mem_data_out=0xA5A5A5A5 while granted; port_ack[0] follows mem_ack.
- Contention: ports 0 and 1 request simultaneously after reset, both re-request immediately on ack -> grant order 0,1,0,1 over 4 transactions.
- Sticky controller ack: model holds mem_ack high 3 cycles after mem_req drops -> no new grant until mem_ack low, then grant next eligible port the following edge.
- Protocol violation: port1 drops req during BUSY -> transaction completes, port_ack[1] stays 0, next arbitration proceeds normally.
